// File: rtl/mem_pkg.sv
// Shared types and access-code helpers for the wait-state data memory.
// Access codes mirror the MEM_* encodings used by the load/store unit.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE   = 4'd0,
    MEM_LOAD1  = 4'd1,
    MEM_LOAD1U = 4'd2,
    MEM_LOAD2  = 4'd3,
    MEM_LOAD2U = 4'd4,
    MEM_LOAD4  = 4'd5,
    MEM_STORE1 = 4'd6,
    MEM_STORE2 = 4'd7,
    MEM_STORE4 = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_LOAD1, MEM_LOAD1U, MEM_LOAD2,
                      MEM_LOAD2U, MEM_LOAD4};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_STORE1, MEM_STORE2, MEM_STORE4};
  endfunction

  function automatic size_e access_size(input logic [3:0] op);
    size_e sz;
    sz = SZ_W;
    if (op inside {MEM_LOAD1, MEM_LOAD1U, MEM_STORE1})
      sz = SZ_B;
    else if (op inside {MEM_LOAD2, MEM_LOAD2U, MEM_STORE2})
      sz = SZ_H;
    return sz;
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return op inside {MEM_LOAD1, MEM_LOAD2};
  endfunction

  function automatic logic misaligned(input logic [3:0] op,
                                      input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (is_load(op) || is_store(op)) begin
      if (access_size(op) == SZ_H)
        m = lo[0];
      else if (access_size(op) == SZ_W)
        m = |lo;
    end
    return m;
  endfunction

endpackage

// File: rtl/data_mem_lane_fmt.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; sub-size offsets below the access size are ignored.
module data_mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  // Lane enables, replicated write data and extended load data
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    byte_v  = rword_i[{lo_i, 3'b000} +: 8];
    half_v  = lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    sgn     = is_signed(op_i);
    if (is_store(op_i)) begin
      unique case (access_size(op_i))
        SZ_B: begin
          be_o    = 4'b0001 << lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_H: begin
          be_o    = lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end else if (is_load(op_i)) begin
      unique case (access_size(op_i))
        SZ_B:
          rdata_o = {{24{sgn & byte_v[7]}}, byte_v};
        SZ_H:
          rdata_o = {{16{sgn & half_v[15]}}, half_v};
        default:
          rdata_o = rword_i;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_ws.sv
// Wait-state data memory: valid/ready request, one-cycle response strobe.
// DATA_MEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module data_mem_ws
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept, enter_resp, bad, we;
  logic [3:0]       cur_op;
  logic [31:0]      cur_addr, cur_wdata;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wword, fmt_rdata;
  logic             unused_hi;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;

  assign accept = req_valid && req_ready && (mem_ctrl != MEM_NONE);

  assign cur_op    = req_ready ? mem_ctrl : op_q;
  assign cur_addr  = req_ready ? addr     : addr_q;
  assign cur_wdata = req_ready ? data_in  : wdata_q;
  assign idx       = cur_addr[IDX_W+1:2];
  assign unused_hi = ^cur_addr[31:IDX_W+2];

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign bad = !(is_load(cur_op) || is_store(cur_op)) ||
               misaligned(cur_op, cur_addr[1:0]);
`else
  assign bad = !(is_load(cur_op) || is_store(cur_op));
`endif

  assign we = enter_resp && !rst && is_store(cur_op) && !bad;

  data_mem_lane_fmt u_fmt (
    .op_i    (cur_op),
    .lo_i    (cur_addr[1:0]),
    .wdata_i (cur_wdata),
    .rword_i (mem_q[idx]),
    .be_o    (be),
    .wdata_o (wword),
    .rdata_o (fmt_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = ST_RESP;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ST_RESP:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= mem_ctrl;
        addr_q  <= addr;
        wdata_q <= data_in;
      end
      if (enter_resp) begin
        rdata_q <= bad ? 32'd0 : fmt_rdata;
        err_q   <= bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ws.sv
// Directed plus randomized checks of data_mem_ws against a byte-level model.
// Build with DATA_MEM_MISALIGN_CHECK_EN to expect misaligned-access errors.
module tb_data_mem_ws;
  import mem_pkg::*;

  localparam int WAIT = 2;
  localparam int DEPTH = 256;
  localparam int SPAN = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [7:0] mb [int];

  data_mem_ws #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAIT),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_ctrl  (mem_ctrl),
    .addr      (addr),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference: little-endian bytes, aliasing modulo SPAN
  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a,
                                input logic [31:0] d,
                                output logic [31:0] rd,
                                output logic er);
    int n;
    int base;
    bit st;
    bit sg;
    logic [31:0] v;
    n = 0; st = 0; sg = 0;
    rd = 32'd0; er = 1'b0;
    case (op)
      MEM_LOAD1:  begin n = 1; sg = 1; end
      MEM_LOAD1U: n = 1;
      MEM_LOAD2:  begin n = 2; sg = 1; end
      MEM_LOAD2U: n = 2;
      MEM_LOAD4:  n = 4;
      MEM_STORE1: begin n = 1; st = 1; end
      MEM_STORE2: begin n = 2; st = 1; end
      MEM_STORE4: begin n = 4; st = 1; end
      default:    n = 0;
    endcase
    if (n == 0) begin
      er = 1'b1;
      return;
    end
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if ((a % n) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    base = int'(a % SPAN);
    base = base - (base % n);
    if (st) begin
      for (int k = 0; k < n; k++)
        mb[base + k] = d[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++)
        v = v | (32'(mb[base + k]) << (8 * k));
      if (sg && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  task automatic access(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd,
                        output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    bit          got;
    model(op, a, d, exp_rd, exp_er);
    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = op;
    addr      = a;
    data_in   = d;
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ctrl  = MEM_NONE;
    addr      = '0;
    data_in   = '0;
    chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(WAIT + 1));
    rd = rdata;
    er = err;
    chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".err"}, 32'(err), 32'(exp_er));
    @(posedge clk);
    #1;
    chk({tag, ".strobe_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rdata_hold"}, rdata, rd);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [3:0]  rops [9];
  logic [31:0] ra;
  bit          seen;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_ctrl  = MEM_NONE;
    addr      = '0;
    data_in   = '0;
    #1;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    access("t1.st4", MEM_STORE4, 32'h10, 32'hDEAD_BEEF, rd, er);
    chk("t1.st_rdata", rd, 32'd0);
    access("t1.ld4", MEM_LOAD4, 32'h10, 32'h0, rd, er);
    chk("t1.ld_val", rd, 32'hDEAD_BEEF);

    access("t2.init", MEM_STORE4, 32'h10, 32'h1122_3344, rd, er);
    access("t2.st1", MEM_STORE1, 32'h13, 32'h0000_00A5, rd, er);
    access("t2.ld4", MEM_LOAD4, 32'h10, 32'h0, rd, er);
    chk("t2.ld4_val", rd, 32'hA522_3344);
    access("t2.ld1", MEM_LOAD1, 32'h13, 32'h0, rd, er);
    chk("t2.ld1_val", rd, 32'hFFFF_FFA5);
    access("t2.ld1u", MEM_LOAD1U, 32'h13, 32'h0, rd, er);
    chk("t2.ld1u_val", rd, 32'h0000_00A5);

    access("t3.init", MEM_STORE4, 32'h20, 32'h0, rd, er);
    access("t3.st2", MEM_STORE2, 32'h22, 32'h0000_8001, rd, er);
    access("t3.ld2", MEM_LOAD2, 32'h22, 32'h0, rd, er);
    chk("t3.ld2_val", rd, 32'hFFFF_8001);
    access("t3.ld2u", MEM_LOAD2U, 32'h22, 32'h0, rd, er);
    chk("t3.ld2u_val", rd, 32'h0000_8001);
    access("t3.ld4", MEM_LOAD4, 32'h20, 32'h0, rd, er);
    chk("t3.ld4_val", rd, 32'h8001_0000);

    access("t4.st4", MEM_STORE4, 32'h404, 32'h1234_5678, rd, er);
    access("t4.ld4", MEM_LOAD4, 32'h004, 32'h0, rd, er);
    chk("t4.alias_val", rd, 32'h1234_5678);
    chk("t4.alias_err", 32'(er), 32'd0);

    access("t5.init", MEM_STORE4, 32'h40, 32'h0102_0304, rd, er);
    access("t5.ld4a", MEM_LOAD4, 32'h40, 32'h0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = MEM_STORE4;
    addr      = 32'h40;
    data_in   = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ctrl  = MEM_NONE;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5.rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5.rst_rdata", rdata, 32'd0);
    chk("t5.rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    chk("t5.no_rsp", 32'(seen), 32'd0);
    access("t5.ld4b", MEM_LOAD4, 32'h40, 32'h0, rd, er);
    chk("t5.old_val", rd, 32'h0102_0304);

    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = MEM_NONE;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid || !req_ready) seen = 1;
    end
    req_valid = 1'b0;
    chk("t5.none_ignored", 32'(seen), 32'd0);

    access("t6.init", MEM_STORE4, 32'h30, 32'hCAFE_F00D, rd, er);
    access("t6.st4m", MEM_STORE4, 32'h31, 32'h55AA_55AA, rd, er);
    access("t6.ld4", MEM_LOAD4, 32'h30, 32'h0, ra, er);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    chk("t6.word_kept", ra, 32'hCAFE_F00D);
`else
    chk("t6.word_written", ra, 32'h55AA_55AA);
`endif

    access("t7.badop", 4'hB, 32'h10, 32'h0, rd, er);
    chk("t7.bad_err", 32'(er), 32'd1);
    chk("t7.bad_rdata", rd, 32'd0);

    for (int w = 0; w < 16; w++)
      access("rnd.init", MEM_STORE4, 32'h100 + 32'(4 * w),
             $urandom, rd, er);
    rops[0] = MEM_LOAD1;  rops[1] = MEM_LOAD1U;
    rops[2] = MEM_LOAD2;  rops[3] = MEM_LOAD2U;
    rops[4] = MEM_LOAD4;  rops[5] = MEM_STORE1;
    rops[6] = MEM_STORE2; rops[7] = MEM_STORE4;
    rops[8] = 4'hB;
    for (int i = 0; i < 60; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 63));
      ra = ra | (32'($urandom_range(0, 3)) << 10);
      access("rnd", rops[$urandom_range(0, 8)], ra, $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
